// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key indices, matrix geometry, replay FSM states
// and the key-to-row/column mapping used by both the replayer and the scanner.
package keypad_pkg;

    localparam int NUM_KEYS = 12;
    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 3;

    // Key indices in the order the pattern bits are assigned.
    localparam logic [3:0] KEY_1    = 4'd0;
    localparam logic [3:0] KEY_2    = 4'd1;
    localparam logic [3:0] KEY_3    = 4'd2;
    localparam logic [3:0] KEY_4    = 4'd3;
    localparam logic [3:0] KEY_5    = 4'd4;
    localparam logic [3:0] KEY_6    = 4'd5;
    localparam logic [3:0] KEY_7    = 4'd6;
    localparam logic [3:0] KEY_8    = 4'd7;
    localparam logic [3:0] KEY_9    = 4'd8;
    localparam logic [3:0] KEY_STAR = 4'd9;
    localparam logic [3:0] KEY_0    = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEEK  = 3'd1,
        ST_PRESS = 3'd2,
        ST_GAP   = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    function automatic logic [1:0] key_row(input logic [3:0] k);
        logic [3:0] q;
        q = k / 4'd3;
        return q[1:0];
    endfunction

    function automatic logic [1:0] key_col(input logic [3:0] k);
        logic [3:0] r;
        r = k % 4'd3;
        return r[1:0];
    endfunction

endpackage

// File: rtl/keypad_sense_mux.sv
// Registered column-sense generator: answers the scanner's row strobe with the
// column of the key being held, or nothing when no key is enabled.
module keypad_sense_mux
    import keypad_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_ROWS-1:0] i_row_strobe,
    input  logic [3:0]          i_key,
    input  logic                i_en,
    output logic [NUM_COLS-1:0] o_col_sense
);

    logic [1:0]          w_row;
    logic [1:0]          w_col;
    logic                w_hit;
    logic [NUM_COLS-1:0] w_col_oh;
    logic [NUM_COLS-1:0] r_col_sense;

    // Any strobed row that matches the key's row answers, so multi-row strobes OR naturally.
    always_comb begin
        w_row    = key_row(i_key);
        w_col    = key_col(i_key);
        w_hit    = i_en && i_row_strobe[w_row];
        w_col_oh = '0;
        if (w_hit) begin
            w_col_oh = NUM_COLS'(1) << w_col;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col_sense <= '0;
        end else begin
            r_col_sense <= w_col_oh;
        end
    end

    assign o_col_sense = r_col_sense;

endmodule

// File: rtl/keypad_replay.sv
// Replays a 12-key pattern into a scanned keypad matrix, lowest key first, with
// fixed hold and release times. Define KEYPAD_REPLAY_BOUNCE_EN for contact bounce.
module keypad_replay
    import keypad_pkg::*;
#(
    parameter int HOLD_CYC   = 1000,
    parameter int GAP_CYC    = 1000,
    parameter int BOUNCE_CYC = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_ROWS-1:0] row_strobe,
    output logic [NUM_COLS-1:0] col_sense,
    input  logic [NUM_KEYS-1:0] pattern,
    input  logic                start,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic [3:0]          cur_key,
    output state_t              dbg_state
);

    // Handshake: start is a one-cycle request honoured only in IDLE with abort low;
    // busy covers the whole replay, done pulses once on normal completion only.

    localparam int MAX_AB  = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int MAX_CYC = (MAX_AB > BOUNCE_CYC) ? MAX_AB : BOUNCE_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYC - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [NUM_KEYS-1:0] r_shadow;
    logic [NUM_KEYS-1:0] w_shadow_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_next;
    logic [3:0]          r_key;
    logic [3:0]          w_key_next;
    logic                r_busy;
    logic                r_done;
    logic [3:0]          w_sel;
    logic                w_found;
    logic                w_press_en;

    // Lowest set shadow bit wins: scan from the top so the last hit is the lowest.
    always_comb begin
        w_sel   = 4'd0;
        w_found = |r_shadow;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (r_shadow[i]) begin
                w_sel = 4'(i);
            end
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_shadow_next = r_shadow;
        w_cnt_next    = r_cnt;
        w_key_next    = r_key;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state  = ST_SEEK;
                    w_shadow_next = pattern;
                    w_cnt_next    = '0;
                end
            end
            ST_SEEK: begin
                if (w_found) begin
                    w_next_state         = ST_PRESS;
                    w_shadow_next[w_sel] = 1'b0;
                    w_key_next           = w_sel;
                    w_cnt_next           = HOLD_LD;
                end else begin
                    w_next_state = ST_FIN;
                    w_cnt_next   = '0;
                end
            end
            ST_PRESS: begin
                if (r_cnt == '0) begin
                    w_next_state = ST_GAP;
                    w_cnt_next   = GAP_LD;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            ST_GAP: begin
                if (r_cnt == '0) begin
                    w_next_state = ST_SEEK;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            ST_FIN: begin
                w_next_state = ST_IDLE;
                w_cnt_next   = '0;
            end
            default: begin
                w_next_state = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
        // abort overrides everything, including a start in the same cycle.
        if (abort) begin
            w_next_state  = ST_IDLE;
            w_shadow_next = '0;
            w_cnt_next    = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_shadow <= '0;
            r_cnt    <= '0;
            r_key    <= 4'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_shadow <= w_shadow_next;
            r_cnt    <= w_cnt_next;
            r_key    <= w_key_next;
            r_busy   <= (w_next_state != ST_IDLE);
            r_done   <= (w_next_state == ST_FIN);
        end
    end

`ifdef KEYPAD_REPLAY_BOUNCE_EN
    localparam logic [CNT_W-1:0] BOUNCE_LIM = CNT_W'(BOUNCE_CYC);
    logic [CNT_W-1:0] w_elapsed;
    logic             w_bounce_on;

    // Elapsed press time is recovered from the down-counter; contact toggles every 8 clocks.
    always_comb begin
        w_elapsed   = HOLD_LD - r_cnt;
        w_bounce_on = (w_elapsed < BOUNCE_LIM) ? ~w_elapsed[3] : 1'b1;
        w_press_en  = (r_state == ST_PRESS) && !abort && w_bounce_on;
    end
`else
    assign w_press_en = (r_state == ST_PRESS) && !abort;
`endif

    keypad_sense_mux u_sense_mux (
        .clk          (clk),
        .rst          (rst),
        .i_row_strobe (row_strobe),
        .i_key        (r_key),
        .i_en         (w_press_en),
        .o_col_sense  (col_sense)
    );

    assign busy      = r_busy;
    assign done      = r_done;
    assign cur_key   = r_key;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_keypad_replay.sv
// Bench for keypad_replay: directed scenarios plus random patterns and strobes
// checked against a phase-timeline model of the replay.
module tb_keypad_replay;
    import keypad_pkg::*;

    localparam int HOLD   = 4;
    localparam int GAP    = 2;
    localparam int BOUNCE = 16;

    localparam int K_IDLE  = 0;
    localparam int K_SEEK  = 1;
    localparam int K_PRESS = 2;
    localparam int K_GAP   = 3;
    localparam int K_FIN   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row_strobe = 4'd0;
    logic [2:0]  col_sense;
    logic [11:0] pattern = 12'd0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        busy;
    logic        done;
    logic [3:0]  cur_key;
    state_t      dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    logic [3:0] exp_cur = 4'd0;

    int ph_kind[$];
    int ph_key[$];
    int ph_el[$];

    keypad_replay #(
        .HOLD_CYC   (HOLD),
        .GAP_CYC    (GAP),
        .BOUNCE_CYC (BOUNCE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .row_strobe (row_strobe),
        .col_sense  (col_sense),
        .pattern    (pattern),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .cur_key    (cur_key),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Replay timeline: per key one SEEK, HOLD press clocks, GAP release clocks; then SEEK, FIN.
    function automatic void build(input logic [11:0] pat);
        ph_kind.delete();
        ph_key.delete();
        ph_el.delete();
        for (int k = 0; k < 12; k++) begin
            if (pat[k]) begin
                ph_kind.push_back(K_SEEK);  ph_key.push_back(0); ph_el.push_back(0);
                for (int e = 0; e < HOLD; e++) begin
                    ph_kind.push_back(K_PRESS); ph_key.push_back(k); ph_el.push_back(e);
                end
                for (int e = 0; e < GAP; e++) begin
                    ph_kind.push_back(K_GAP); ph_key.push_back(0); ph_el.push_back(e);
                end
            end
        end
        ph_kind.push_back(K_SEEK); ph_key.push_back(0); ph_el.push_back(0);
        ph_kind.push_back(K_FIN);  ph_key.push_back(0); ph_el.push_back(0);
    endfunction

    function automatic logic [2:0] exp_col(input int kind, input int key, input int el,
                                           input logic [3:0] strobe);
        if (kind != K_PRESS) return 3'd0;
`ifdef KEYPAD_REPLAY_BOUNCE_EN
        if (el < BOUNCE && ((el / 8) % 2) == 1) return 3'd0;
`else
        if (el < 0) return 3'd0;
`endif
        if (strobe[key / 3]) return 3'(1 << (key % 3));
        return 3'd0;
    endfunction

    // One full replay; strobe is either fixed or random per clock. With poke set,
    // a stray start with a different pattern is issued while busy and must be ignored.
    task automatic run_seq(input string name, input logic [11:0] pat, input logic [3:0] fix_strobe,
                           input bit rnd, input bit poke);
        int len, kind, pkind, pkey, pel;
        logic [3:0] pstrobe, s;
        build(pat);
        len = ph_kind.size();
        @(negedge clk);
        pattern = pat;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        pkind = K_IDLE; pkey = 0; pel = 0; pstrobe = 4'd0;
        for (int t = 0; t <= len; t++) begin
            kind = (t < len) ? ph_kind[t] : K_IDLE;
            if (kind == K_PRESS) exp_cur = 4'(ph_key[t]);
            check({name, ".busy"}, 12'(busy), 12'((t < len) ? 1 : 0));
            check({name, ".done"}, 12'(done), 12'((kind == K_FIN) ? 1 : 0));
            check({name, ".cur_key"}, 12'(cur_key), 12'(exp_cur));
            check({name, ".col_sense"}, 12'(col_sense), 12'(exp_col(pkind, pkey, pel, pstrobe)));
            s = rnd ? 4'($urandom_range(0, 15)) : fix_strobe;
            row_strobe = s;
            start   = (poke && len > 2 && t == 2);
            if (start) pattern = 12'($urandom);
            pkind = kind;
            pkey  = (t < len) ? ph_key[t] : 0;
            pel   = (t < len) ? ph_el[t] : 0;
            pstrobe = s;
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst.col_sense", 12'(col_sense), 12'd0);
        check("rst.busy", 12'(busy), 12'd0);
        check("rst.done", 12'(done), 12'd0);
        check("rst.cur_key", 12'(cur_key), 12'd0);
        rst = 1'b0;
        @(negedge clk);

        run_seq("single_key5", 12'h010, 4'b0010, 1'b0, 1'b0);
        run_seq("multi_1_0", 12'h401, 4'b1000, 1'b0, 1'b0);
        run_seq("wrong_row", 12'h001, 4'b1000, 1'b0, 1'b0);
        run_seq("empty", 12'h000, 4'b1111, 1'b0, 1'b0);
        run_seq("all_rows", 12'h801, 4'b1111, 1'b0, 1'b0);

        // abort during the first press: sense drops next clock, rest of pattern discarded
        @(negedge clk);
        pattern = 12'h011; start = 1'b1; row_strobe = 4'b1111;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        exp_cur = 4'd0;
        check("abort.pre_col", 12'(col_sense), 12'h001);
        check("abort.pre_busy", 12'(busy), 12'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort.col", 12'(col_sense), 12'd0);
        check("abort.busy", 12'(busy), 12'd0);
        check("abort.done", 12'(done), 12'd0);
        check("abort.cur_key", 12'(cur_key), 12'(exp_cur));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("abort.after_busy", 12'(busy), 12'd0);
            check("abort.after_done", 12'(done), 12'd0);
            check("abort.after_col", 12'(col_sense), 12'd0);
        end

        // abort and start together: the start is dropped
        pattern = 12'h001; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("collide.busy", 12'(busy), 12'd0);
            check("collide.done", 12'(done), 12'd0);
            check("collide.col", 12'(col_sense), 12'd0);
            @(negedge clk);
        end

        // random patterns and strobes, with stray starts while busy
        for (int n = 0; n < 12; n++) begin
            run_seq("rand", 12'($urandom), 4'd0, 1'b1, 1'b1);
        end

        // reset mid-press clears everything at once, with no done afterwards
        pattern = 12'h010; start = 1'b1; row_strobe = 4'b0010;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst.pre_col", 12'(col_sense), 12'h002);
        #2 rst = 1'b1;
        #1;
        check("midrst.col", 12'(col_sense), 12'd0);
        check("midrst.busy", 12'(busy), 12'd0);
        check("midrst.done", 12'(done), 12'd0);
        check("midrst.cur_key", 12'(cur_key), 12'd0);
        exp_cur = 4'd0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("midrst.after_done", 12'(done), 12'd0);
            check("midrst.after_busy", 12'(busy), 12'd0);
        end

        run_seq("post_rst", 12'h020, 4'b0010, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/keypad_replay.md
KEYPAD_REPLAY -- requirements
Module: keypad_replay

Interface
REQ-001 Parameter HOLD_CYC, default 1000: clocks each key stays pressed.
REQ-002 Parameter GAP_CYC, default 1000: clocks of full release between consecutive keys.
REQ-003 Parameter BOUNCE_CYC, default 64: bounce window length at press start (used only with the macro).
REQ-004 Port clk, input, 1: single clock; all state on its rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port row_strobe, input, 4: one-hot row select driven by the keypad scanner (bit r = row r active-high).
REQ-007 Port col_sense, output, 3: column sense returned to the scanner, active-high.
REQ-008 Port pattern, input, 12: keys to replay; bit k = key k, order 1,2,3,4,5,6,7,8,9,*,0,#.
REQ-009 Port start, input, 1: single-cycle request; latches pattern.
REQ-010 Port abort, input, 1: cancels the replay in progress.
REQ-011 Port busy, output, 1: high from the accepted start until the sequence ends or is aborted.
REQ-012 Port done, output, 1: one-cycle pulse on normal completion.
REQ-013 Port cur_key, output, 4: index (0-11) of the key currently pressed or last pressed.

Function
REQ-014 Key k SHALL map to row k/3 and column k%3.
REQ-015 FSM states SHALL be IDLE, SEEK, PRESS, GAP and FIN.
REQ-016 IDLE: start with abort low SHALL latch pattern into a shadow register, set busy and go to SEEK; start while busy SHALL be ignored.
REQ-017 SEEK: the FSM SHALL select the lowest set shadow bit, clear it, load cur_key and go to PRESS; with no bit set it SHALL go to FIN.
REQ-018 PRESS SHALL last exactly HOLD_CYC clocks, then the FSM SHALL go to GAP.
REQ-019 GAP SHALL last exactly GAP_CYC clocks, then the FSM SHALL go to SEEK.
REQ-020 FIN SHALL pulse done for one clock, clear busy and return to IDLE.
REQ-021 An all-zero pattern SHALL produce a done pulse 2 clocks after start and never assert col_sense.
REQ-022 col_sense SHALL be registered: col_sense[c] equals 1 one clock after row_strobe selects the row of the pressed key while in PRESS, with c being that key's column; otherwise 0.
REQ-023 When row_strobe has several bits set, the SHALL OR the rows together; when row_strobe is 0, col_sense SHALL be 0.
REQ-024 abort SHALL move the FSM to IDLE on the next clock, force col_sense to 0, clear busy, leave done low and discard the shadow pattern.
REQ-025 abort asserted in the same cycle as start SHALL take priority, and the start SHALL be dropped.
REQ-026 The hold/gap counter SHALL be wide enough for max(HOLD_CYC, GAP_CYC, BOUNCE_CYC) and SHALL reload on every state entry, with no wrap-around.

Reset
REQ-027 rst SHALL asynchronously force IDLE, col_sense=0, busy=0, done=0, cur_key=0, shadow=0 and counter=0.
REQ-028 Reset asserted mid-replay SHALL abandon the sequence without a done pulse.

Configuration
REQ-029 Macro KEYPAD_REPLAY_BOUNCE_EN: when defined, during the first BOUNCE_CYC clocks of PRESS the active sense bit SHALL toggle every 8 clocks, starting asserted, with steady assertion for the rest of PRESS.
REQ-030 Without KEYPAD_REPLAY_BOUNCE_EN, the sense bit SHALL be steady for the whole of PRESS, and no bounce logic SHALL be present.

Structure
REQ-031 Shared package keypad_pkg SHALL hold the key-index constants, NUM_KEYS=12, NUM_ROWS=4, NUM_COLS=3 and the FSM state enum.
REQ-032 The package SHALL hold the key-to-row and key-to-column mapping functions, shared with the scanner.
REQ-033 One sub-module keypad_sense_mux (row_strobe + pressed key -> registered col_sense) is natural; the FSM and counters SHALL stay in keypad_replay.

Verification (HOLD_CYC=4, GAP_CYC=2, macro off)
REQ-034 Single key: pattern=12'h010 (key 5), start, row_strobe=4'b0010 held -> col_sense=3'b010 for 4 clocks, then 0, then done pulse; cur_key=4.
REQ-035 Multi-key ordering: pattern=12'h401 (keys 1, 0) -> cur_key sequence 0 then 10; row 3 strobe returns col_sense=3'b010 only during the second PRESS.
REQ-036 Wrong row: pattern=12'h001 with row_strobe=4'b1000 -> col_sense stays 0; done pulse still asserted.
REQ-037 Abort/start collision: abort and start high on the same clock -> busy stays 0, no done pulse; abort during PRESS -> col_sense=0 next clock, busy=0, no done pulse.
REQ-038 Empty pattern and reset: pattern=0 -> done 2 clocks after start; rst pulse mid-PRESS -> all outputs 0 immediately.
REQ-039 Bounce: macro on, BOUNCE_CYC=16 -> col_sense toggles at 8-clock intervals for 16 clocks, then stays steady until the end of PRESS.
